// File: rtl/meter_sequencer.sv
// Parking-meter control: owns the remaining-time register, applies coin/preset requests
// with saturation, and sequences the external one-second decrementer.
//
// state | meaning
// IDLE  | time is zero; requests load the register directly, ticks ignored
// RUN   | time is nonzero; requests applied at once, sec_tick starts a decrement
// WAIT  | decrement in flight; requests merged into pending, applied on capture
module meter_sequencer #(
  parameter int CLK_PER_SEC = 100,
  parameter int DEC_LATENCY = 1,
  parameter int MAX_TIME    = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add_50,
  input  logic        add_150,
  input  logic        add_200,
  input  logic        add_500,
  input  logic        set_15,
  input  logic        set_185,
  output logic        EA,
  output logic [13:0] Timein,
  input  logic [13:0] Timeout,
  output logic [13:0] time_left,
  output logic        expired,
  output logic        blink
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int WW = (DEC_LATENCY > 0) ? $clog2(DEC_LATENCY + 1) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(CLK_PER_SEC - 1);
  localparam logic [PW-1:0] PSC_HALF = PW'(CLK_PER_SEC / 2 - 1);
  localparam logic [13:0]   TMAX     = 14'(MAX_TIME);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  state_t        state;
  logic [13:0]   time_reg;
  logic [13:0]   pend_reg;
  logic          pend_set;
  logic [WW-1:0] wcnt;
  logic [PW-1:0] psc;

  logic          sec_tick;
  logic          half_tick;
  logic          req_load;
  logic          req_add;
  logic [13:0]   req_val;
  logic [13:0]   add_sum;
  logic [13:0]   run_val;
  logic          mp_set;
  logic [13:0]   mp_val;
  logic [13:0]   cap_val;
  logic          cap_done;

  function automatic logic [13:0] sat_add(input logic [13:0] a, input logic [13:0] b);
    logic [14:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, TMAX}) ? TMAX : s[13:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) psc <= '0;
    else        psc <= (psc == PSC_LAST) ? '0 : psc + PW'(1);
  end

  assign sec_tick  = (psc == PSC_LAST);
  assign half_tick = sec_tick || (psc == PSC_HALF);

  always_comb begin
    add_sum  = (add_50  ? 14'd50  : 14'd0) + (add_150 ? 14'd150 : 14'd0)
             + (add_200 ? 14'd200 : 14'd0) + (add_500 ? 14'd500 : 14'd0);
    req_load = set_185 || set_15;
    req_add  = !req_load && (add_50 || add_150 || add_200 || add_500);
    req_val  = set_185 ? 14'd185 : (set_15 ? 14'd15 : add_sum);

    if (req_load)     run_val = req_val;
    else if (req_add) run_val = sat_add(time_reg, req_val);
    else              run_val = time_reg;

    // A load replaces the pending entry; adds stack on whatever is pending, load or not.
    mp_set = pend_set || req_load;
    if (req_load)     mp_val = req_val;
    else if (req_add) mp_val = sat_add(pend_reg, req_val);
    else              mp_val = pend_reg;

    cap_val  = mp_set ? mp_val : sat_add(Timeout, mp_val);
    cap_done = (state == WAIT) && (wcnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      time_reg <= '0;
      pend_reg <= '0;
      pend_set <= 1'b0;
      wcnt     <= '0;
      EA       <= 1'b0;
      expired  <= 1'b1;
      blink    <= 1'b0;
    end else begin
      EA <= 1'b0;
      case (state)
        IDLE: begin
          time_reg <= run_val;
          expired  <= (run_val == '0);
          if (run_val != '0) state <= RUN;
        end
        RUN: begin
          time_reg <= run_val;
          expired  <= (run_val == '0);
          if (sec_tick && time_reg != '0) begin
            EA    <= 1'b1;
            wcnt  <= WW'(DEC_LATENCY);
            state <= WAIT;
          end else if (run_val == '0) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wcnt == '0) begin
            time_reg <= cap_val;
            expired  <= (cap_val == '0);
            pend_set <= 1'b0;
            pend_reg <= '0;
            state    <= (cap_val != '0) ? RUN : IDLE;
          end else begin
            wcnt     <= wcnt - WW'(1);
            pend_set <= mp_set;
            pend_reg <= mp_val;
          end
        end
        default: state <= IDLE;
      endcase

      // Expiry on capture starts the fast blink from a known lit phase.
      if (cap_done && cap_val == '0)                blink <= 1'b1;
      else if ((time_reg != '0) ? sec_tick : half_tick) blink <= ~blink;
    end
  end

  assign Timein    = time_reg;
  assign time_left = time_reg;

endmodule

// File: tb/tb_meter_sequencer.sv
// Scoreboarded bench for meter_sequencer with a one-cycle decrementer model.
module tb_meter_sequencer;
  localparam int CPS = 10;
  localparam logic [5:0] A50  = 6'h01;
  localparam logic [5:0] A150 = 6'h02;
  localparam logic [5:0] A200 = 6'h04;
  localparam logic [5:0] A500 = 6'h08;
  localparam logic [5:0] S15  = 6'h10;
  localparam logic [5:0] S185 = 6'h20;
  localparam logic [5:0] AALL = 6'h0F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        add_50 = 1'b0, add_150 = 1'b0, add_200 = 1'b0, add_500 = 1'b0;
  logic        set_15 = 1'b0, set_185 = 1'b0;
  logic        EA;
  logic [13:0] Timein;
  logic [13:0] Timeout = '0;
  logic [13:0] time_left;
  logic        expired;
  logic        blink;

  int    n_vec = 0;
  int    n_err = 0;
  string tag_q[$];
  int    exp_q[$];
  int    ea_cnt = 0;
  logic  ea_prev = 1'b0;
  int    cyc = 0, last_tog = 0, last_gap = 0;
  logic  blink_prev = 1'b0;
  int    n0;

  meter_sequencer #(.CLK_PER_SEC(CPS), .DEC_LATENCY(1), .MAX_TIME(9999)) dut (
    .clk(clk), .rst_n(rst_n),
    .add_50(add_50), .add_150(add_150), .add_200(add_200), .add_500(add_500),
    .set_15(set_15), .set_185(set_185),
    .EA(EA), .Timein(Timein), .Timeout(Timeout),
    .time_left(time_left), .expired(expired), .blink(blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (EA) Timeout <= Timein - 14'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic expect_pop(input logic [31:0] obs);
    string t;
    int    e;
    if (exp_q.size() == 0) chk("sb_underflow", 0, 1);
    else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, obs, e);
    end
  endtask

  task automatic drive(input logic [5:0] m);
    {set_185, set_15, add_500, add_200, add_150, add_50} = m;
  endtask

  task automatic step(input logic [5:0] m, input int exp, input string tag);
    drive(m);
    expect_push(tag, exp);
    @(negedge clk);
    drive(6'h00);
    expect_pop(time_left);
  endtask

  task automatic wait_ea(input string tag);
    int  i;
    bit  found;
    i = 0;
    found = 1'b0;
    while (!found && i < 3 * CPS) begin
      @(negedge clk);
      if (EA === 1'b1) found = 1'b1;
      i++;
    end
    if (!found) chk({tag, "_ea_timeout"}, 0, 1);
  endtask

  // m_e lands in the EA cycle, m_c in the capture cycle; both are WAIT requests.
  task automatic ea_cycle(input int tin, input int cap, input logic [5:0] m_e,
                          input logic [5:0] m_c, input string tag);
    expect_push({tag, "_timein"}, tin);
    wait_ea(tag);
    expect_pop(Timein);
    drive(m_e);
    expect_push({tag, "_capture"}, cap);
    @(negedge clk);
    drive(m_c);
    @(negedge clk);
    drive(6'h00);
    expect_pop(time_left);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n && EA) begin
      ea_cnt++;
      chk("ea_timein_nonzero", Timein != 14'd0, 1);
      chk("ea_single_cycle", ea_prev, 0);
    end
    ea_prev = EA;
    if (blink !== blink_prev) begin
      last_gap = cyc - last_tog;
      last_tog = cyc;
    end
    blink_prev = blink;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    drive(6'h00);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_time_left", time_left, 0);
    chk("rst_expired", expired, 1);
    chk("rst_ea", EA, 0);
    chk("rst_timein", Timein, 0);
    chk("rst_blink", blink, 0);
    rst_n = 1'b1;

    step(A500, 500, "idle_add500");
    chk("add500_expired", expired, 0);
    n0 = ea_cnt;
    ea_cycle(500, 499, 6'h00, 6'h00, "dec1");
    ea_cycle(499, 498, 6'h00, 6'h00, "dec2");
    ea_cycle(498, 497, 6'h00, 6'h00, "dec3");
    chk("ea_count_3s", ea_cnt - n0, 3);

    ea_cycle(497, 646, 6'h00, A150, "capture_add150");

    step(S15 | A500, 15, "load15_beats_add");
    step(S185 | S15 | A200, 185, "load185_priority");
    step(A200 | A150 | A50, 585, "multi_add");
    ea_cycle(585, 185, S185, 6'h00, "wait_load185");
    ea_cycle(185, 65, S15, A50, "wait_load_then_add");
    ea_cycle(65, 314, A50, A200, "wait_add_accum");

    step(S185, 185, "sat_load");
    step(AALL, 1085, "sat_a1");
    step(AALL, 1985, "sat_a2");
    step(AALL, 2885, "sat_a3");
    step(AALL, 3785, "sat_a4");
    step(AALL, 4685, "sat_a5");
    step(AALL, 5585, "sat_a6");
    ea_cycle(5585, 5584, 6'h00, 6'h00, "sat_dec");
    step(AALL, 6484, "sat_b1");
    step(AALL, 7384, "sat_b2");
    step(AALL, 8284, "sat_b3");
    step(AALL, 9184, "sat_b4");
    step(A500, 9684, "sat_b5");
    step(A500 | A200, 9999, "sat_clamp");
    step(AALL, 9999, "sat_hold");
    ea_cycle(9999, 9999, A500, 6'h00, "sat_wait_clamp");

    step(S15, 15, "run15_load");
    for (int k = 15; k >= 1; k--) begin
      ea_cycle(k, k - 1, 6'h00, 6'h00, "run15");
      if (k == 12) chk("blink_run_period", last_gap, CPS);
    end
    chk("expire_flag", expired, 1);
    chk("expire_blink_forced", blink, 1);
    n0 = ea_cnt;
    repeat (40) @(negedge clk);
    chk("idle_no_ea", ea_cnt - n0, 0);
    chk("blink_idle_half", last_gap, CPS / 2);
    chk("idle_time_left", time_left, 0);

    step(S185, 185, "idle_load185");
    chk("idle_load_expired", expired, 0);
    expect_push("rstwait_timein", 185);
    wait_ea("rstwait");
    expect_pop(Timein);
    drive(A50);
    @(posedge clk);
    #2;
    drive(6'h00);
    rst_n = 1'b0;
    #1;
    chk("rstwait_ea", EA, 0);
    chk("rstwait_time_left", time_left, 0);
    chk("rstwait_expired", expired, 1);
    chk("rstwait_timein", Timein, 0);
    n0 = ea_cnt;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst_no_stale_add", time_left, 0);
    chk("post_rst_expired", expired, 1);
    chk("post_rst_no_ea", ea_cnt - n0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
